// File: rtl/draw_screen_ctrl_if.sv
// -----------------------------------------------------------------------------
// vga_pkg / vga_if
//
// Purpose:
//   Shared VGA constants, the pipeline payload struct, and the VGA stream
//   interface that carries timing and colour between pipeline stages.
//
// vga_if signals:
//   hcount, vcount  pixel counters (CNT_W bits)
//   hsync, vsync    sync pulses
//   hblnk, vblnk    blanking flags
//   rgb             12-bit colour {r,g,b}
//
// Modports:
//   in  / slave   consumer side, where all signals are inputs
//   out / master  producer side, where all signals are outputs
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
    localparam int CNT_W      = 11;

    // One pixel's worth of timing plus colour, used for the delay line.
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [11:0]      rgb;
    } vga_sig_t;

endpackage

interface vga_if;

    logic [vga_pkg::CNT_W-1:0] hcount;
    logic [vga_pkg::CNT_W-1:0] vcount;
    logic                      hsync;
    logic                      vsync;
    logic                      hblnk;
    logic                      vblnk;
    logic [11:0]               rgb;

    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_screen_ctrl.sv
// -----------------------------------------------------------------------------
// draw_screen_ctrl
//
// Purpose:
//   Draws the menu bitmap, the game background or a per-winner result screen
//   into the VGA stream for NUM_PLAYERS players. It sits after timing
//   generation and before the game-object drawers. The screen state only
//   changes at a frame boundary, which is the rising edge of in.vsync, so a
//   frame never tears.
//
// Optional feature:
//   `define DRAW_SCREEN_BLINK_EN to make the result screen blink. It
//   alternates between the winner colour and the menu image every
//   BLINK_FRAMES frames.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous reset, active low
//   game_en     level input: players request or keep the game running
//   win         level input: win[k] means player k has won
//   rgb_pixel   menu ROM data, valid 1 cycle after pixel_addr
//   pixel_addr  menu ROM address {row, col}, scaled by 2**SCALE_SHIFT
//   state_o     current screen: 0 MENU, 1 GAME, 2 WIN
//   winner_o    index of the latched winner, valid in WIN
//   in          VGA timing and rgb from upstream
//   out         VGA timing and rgb to downstream (3 cycles of latency)
// -----------------------------------------------------------------------------
module draw_screen_ctrl
    import vga_pkg::*;
#(
    parameter int                          NUM_PLAYERS  = 2,
    parameter int                          SCALE_SHIFT  = 3,
    parameter int                          ADDR_W       = 7,
    parameter logic [11:0]                 GAME_RGB     = 12'h000,
    parameter logic [11:0]                 BLANK_RGB    = 12'h888,
    parameter logic [NUM_PLAYERS*12-1:0]   WIN_RGB      = {12'hF0A, 12'hFFF},
    parameter int                          BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    game_en,
    input  logic [NUM_PLAYERS-1:0]  win,
    input  logic [11:0]             rgb_pixel,
    output logic [2*ADDR_W-1:0]     pixel_addr,
    output logic [1:0]              state_o,
    output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner_o,
    vga_if.in                       in,
    vga_if.out                      out
);

    localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    localparam logic [CNT_W-1:0] HOR_LIM = CNT_W'(HOR_PIXELS);
    localparam logic [CNT_W-1:0] VER_LIM = CNT_W'(VER_PIXELS);

    // Catch parameter values the design cannot support at elaboration time.
    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
        $error("draw_screen_ctrl: NUM_PLAYERS must be 1..8");
    end
    if (ADDR_W < 1 || ADDR_W > CNT_W) begin : g_bad_addr
        $error("draw_screen_ctrl: ADDR_W must be 1..CNT_W");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("draw_screen_ctrl: BLINK_FRAMES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_MENU = 2'd0,
        S_GAME = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   winner_q, winner_d;
    logic [WIN_W-1:0]   win_idx;
    logic               vsync_q;
    logic               frame_pulse;
    logic               show_menu_in_win;

    vga_sig_t           in_sig, d1_q, d2_q;
    logic [11:0]        rgb_next;
    logic [11:0]        win_colour;

    // ------------------------------------------------------------------
    // Frame boundary: a one-cycle pulse on the rising edge of in.vsync.
    // ------------------------------------------------------------------
    assign frame_pulse = in.vsync & ~vsync_q;

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the clock edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= in.vsync;
        end
    end

    // ------------------------------------------------------------------
    // Lowest set win bit. Scanning from the top lets lower indices
    // overwrite higher ones, so a tie goes to the lowest player.
    // ------------------------------------------------------------------
    always_comb begin
        win_idx = '0;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (win[k]) begin
                win_idx = WIN_W'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Screen FSM. It only moves on frame_pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_MENU;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (frame_pulse) begin
            unique case (state_q)
                S_MENU: begin
                    if (game_en) begin
                        state_d = S_GAME;
                    end
                end
                S_GAME: begin
                    // A win beats game_en dropping in the same frame.
                    if (|win) begin
                        state_d  = S_WIN;
                        winner_d = win_idx;
                    end else if (!game_en) begin
                        state_d = S_MENU;
                    end
                end
                S_WIN: begin
                    // Further win changes are ignored until the menu.
                    if (!game_en) begin
                        state_d = S_MENU;
                    end
                end
                default: begin
                    state_d = S_MENU;
                end
            endcase
        end
    end

    assign state_o  = state_q;
    assign winner_o = winner_q;

    // ------------------------------------------------------------------
    // Optional result-screen blink.
    // ------------------------------------------------------------------
`ifdef DRAW_SCREEN_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] frame_cnt_q;
    logic               blink_q;

    // The counter stays cleared outside WIN. The entry pulse happens while
    // the state is still GAME, so the first WIN frame always starts at
    // phase 0 with a count of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (state_q != S_WIN) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (frame_pulse) begin
            if (frame_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign show_menu_in_win = blink_q;
`else
    assign show_menu_in_win = 1'b0;
`endif

    // ------------------------------------------------------------------
    // ROM address. The counts are scaled down and truncated, so they wrap
    // rather than saturate. The ROM answers one cycle later, which lines
    // its data up with the second delay stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
        end else begin
            pixel_addr <= {ADDR_W'(in.vcount >> SCALE_SHIFT),
                           ADDR_W'(in.hcount >> SCALE_SHIFT)};
        end
    end

    // ------------------------------------------------------------------
    // Two-stage delay line for the timing and upstream colour.
    // ------------------------------------------------------------------
    assign in_sig = '{hcount: in.hcount, vcount: in.vcount,
                      hsync:  in.hsync,  vsync:  in.vsync,
                      hblnk:  in.hblnk,  vblnk:  in.vblnk,
                      rgb:    in.rgb};

    // NOTE: the delay stages are reset along with the outputs. Without that
    // the first three output cycles after reset would carry X timing into
    // downstream drawers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            d1_q <= in_sig;
            d2_q <= d1_q;
        end
    end

    // ------------------------------------------------------------------
    // Colour select at the delayed stage. Blanking has the highest
    // priority, then pixels outside the visible area, then the screen
    // state.
    // ------------------------------------------------------------------
    assign win_colour = WIN_RGB[12*winner_q +: 12];

    always_comb begin
        rgb_next = d2_q.rgb;
        if (d2_q.hblnk || d2_q.vblnk) begin
            rgb_next = BLANK_RGB;
        end else if (d2_q.vcount >= VER_LIM || d2_q.hcount >= HOR_LIM) begin
            rgb_next = d2_q.rgb;
        end else begin
            unique case (state_q)
                S_MENU:  rgb_next = rgb_pixel;
                S_GAME:  rgb_next = GAME_RGB;
                S_WIN:   rgb_next = show_menu_in_win ? rgb_pixel : win_colour;
                default: rgb_next = d2_q.rgb;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= d2_q.hcount;
            out.vcount <= d2_q.vcount;
            out.hsync  <= d2_q.hsync;
            out.vsync  <= d2_q.vsync;
            out.hblnk  <= d2_q.hblnk;
            out.vblnk  <= d2_q.vblnk;
            out.rgb    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_screen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_draw_screen_ctrl
//
// Purpose:
//   Self-checking bench for draw_screen_ctrl. It uses a table of directed
//   pixel vectors, each tagged with the screen state it must be applied in.
//   Hand-written sequences cover reset, latency, frame sync, tie, priority
//   and blink behaviour.
//
// Menu ROM model:
//   rom(addr) = {4'h3, addr[3:0], addr[10:7]}, registered (1-cycle latency).
//   For hcount=40 and vcount=24 this gives col 5, row 3 and 12'h353.
// -----------------------------------------------------------------------------
module tb_draw_screen_ctrl;
    import vga_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        game_en = 1'b0;
    logic [1:0]  win     = 2'b00;
    logic [11:0] rgb_pixel = 12'h000;
    logic [13:0] pixel_addr;
    logic [1:0]  state_o;
    logic [0:0]  winner_o;

    int total = 0;
    int bad   = 0;

    vga_if vin();
    vga_if vout();

    draw_screen_ctrl #(
        .NUM_PLAYERS  (2),
        .SCALE_SHIFT  (3),
        .ADDR_W       (7),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .game_en    (game_en),
        .win        (win),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .state_o    (state_o),
        .winner_o   (winner_o),
        .in         (vin),
        .out        (vout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rgb_pixel <= {4'h3, pixel_addr[3:0], pixel_addr[10:7]};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb_in;
        logic [1:0]  st;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic vb, input logic vs, input logic [11:0] rgb);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = hb;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
    endtask

    // Holds one pixel for 3 cycles and then returns the output colour.
    task automatic apply_px(input logic [10:0] h, input logic [10:0] v, input logic hb,
                            input logic vb, input logic [11:0] rgb, output logic [11:0] got);
        @(negedge clk);
        drive(h, v, hb, vb, 1'b0, rgb);
        repeat (3) @(negedge clk);
        got = vout.rgb;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        drive(11'd0, 11'd600, 1'b1, 1'b1, 1'b1, 12'h000);
        repeat (2) @(negedge clk);
        vin.vsync = 1'b0;
        @(negedge clk);
    endtask

    // Steers the FSM to the target state with at most 6 frame pulses.
    task automatic goto_state(input logic [1:0] st);
        for (int i = 0; i < 6 && state_o != st; i++) begin
            case (state_o)
                2'd0: begin game_en = (st != 2'd0); win = 2'b00; end
                2'd1: begin
                    if (st == 2'd2) begin game_en = 1'b1; win = 2'b01; end
                    else begin game_en = 1'b0; win = 2'b00; end
                end
                default: begin game_en = 1'b0; win = 2'b00; end
            endcase
            frame_pulse();
        end
        check("goto_state", state_o, st);
    endtask

    logic [11:0] got;
    logic [11:0] blink_exp[6];

    initial begin
        vecs[0]  = '{11'd40,  11'd24,  1'b0, 1'b0, 12'h0C3, 2'd0, 12'h353};
        vecs[1]  = '{11'd799, 11'd599, 1'b0, 1'b0, 12'h0C3, 2'd0, 12'h33A};
        vecs[2]  = '{11'd800, 11'd10,  1'b0, 1'b0, 12'h0C3, 2'd0, 12'h0C3};
        vecs[3]  = '{11'd10,  11'd600, 1'b0, 1'b0, 12'h123, 2'd0, 12'h123};
        vecs[4]  = '{11'd10,  11'd10,  1'b1, 1'b0, 12'h0C3, 2'd0, 12'h888};
        vecs[5]  = '{11'd900, 11'd700, 1'b0, 1'b1, 12'h0C3, 2'd0, 12'h888};
        vecs[6]  = '{11'd40,  11'd24,  1'b0, 1'b0, 12'h0C3, 2'd1, 12'h000};
        vecs[7]  = '{11'd0,   11'd0,   1'b0, 1'b0, 12'h0C3, 2'd1, 12'h000};
        vecs[8]  = '{11'd850, 11'd20,  1'b0, 1'b0, 12'h456, 2'd1, 12'h456};
        vecs[9]  = '{11'd100, 11'd100, 1'b1, 1'b0, 12'h456, 2'd1, 12'h888};
        vecs[10] = '{11'd40,  11'd24,  1'b0, 1'b0, 12'h0C3, 2'd2, 12'hFFF};
        vecs[11] = '{11'd799, 11'd599, 1'b0, 1'b0, 12'h0C3, 2'd2, 12'hFFF};
        vecs[12] = '{11'd810, 11'd5,   1'b0, 1'b0, 12'h789, 2'd2, 12'h789};
        vecs[13] = '{11'd5,   11'd5,   1'b0, 1'b1, 12'h789, 2'd2, 12'h888};
        vecs[14] = '{11'd40,  11'd24,  1'b0, 1'b0, 12'h0C3, 2'd0, 12'h353};

`ifdef DRAW_SCREEN_BLINK_EN
        blink_exp = '{12'hFFF, 12'hFFF, 12'h353, 12'h353, 12'hFFF, 12'hFFF};
`else
        blink_exp = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
`endif

        // Reset is asserted from time 0 with stimulus already active.
        drive(11'd40, 11'd24, 1'b0, 1'b0, 1'b0, 12'h0C3);
        #12;
        check("rst_rgb", vout.rgb, 12'h000);
        check("rst_hcount", vout.hcount, 11'd0);
        check("rst_addr", pixel_addr, 14'd0);
        check("rst_state", state_o, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and address.
        @(negedge clk);
        drive(11'd5, 11'd0, 1'b0, 1'b0, 1'b0, 12'h0AA);
        @(negedge clk);
        drive(11'd17, 11'd9, 1'b0, 1'b0, 1'b0, 12'h0AA);
        @(negedge clk);
        check("lat_addr", pixel_addr, {7'd1, 7'd2});
        drive(11'd1030, 11'd1040, 1'b0, 1'b0, 1'b0, 12'h0AA);
        @(negedge clk);
        check("lat_early", vout.hcount, 11'd5);
        check("wrap_addr", pixel_addr, {7'd2, 7'd0});
        @(negedge clk);
        check("lat_hcount", vout.hcount, 11'd17);
        check("lat_vcount", vout.vcount, 11'd9);

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            if (state_o != vecs[i].st) goto_state(vecs[i].st);
            apply_px(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].rgb_in, got);
            check($sformatf("vec%0d_rgb", i), got, vecs[i].exp);
        end

        // Frame sync: raising game_en mid-frame has no effect until vsync.
        goto_state(2'd0);
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        game_en = 1'b1;
        apply_px(11'd48, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        check("sync_menu_rgb", got, 12'h363);
        check("sync_menu_state", state_o, 2'd0);
        frame_pulse();
        check("sync_game_state", state_o, 2'd1);
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        check("sync_game_rgb", got, 12'h000);

        // Tie: the lowest index wins.
        win = 2'b11;
        frame_pulse();
        check("tie_state", state_o, 2'd2);
        check("tie_winner", winner_o, 1'b0);
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        check("tie_rgb", got, 12'hFFF);
        game_en = 1'b0;
        win = 2'b00;
        frame_pulse();
        check("tie_menu", state_o, 2'd0);

        // A win takes priority over game_en dropping, and win is ignored in WIN.
        goto_state(2'd1);
        win = 2'b10;
        game_en = 1'b0;
        frame_pulse();
        check("prio_state", state_o, 2'd2);
        check("prio_winner", winner_o, 1'b1);
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        check("prio_rgb", got, 12'hF0A);
        game_en = 1'b1;
        win = 2'b01;
        frame_pulse();
        check("hold_state", state_o, 2'd2);
        check("hold_winner", winner_o, 1'b1);
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        check("hold_rgb", got, 12'hF0A);
        game_en = 1'b0;
        win = 2'b00;
        frame_pulse();
        check("exit_menu", state_o, 2'd0);

        // Blink pattern over 6 WIN frames.
        game_en = 1'b1;
        frame_pulse();
        win = 2'b01;
        frame_pulse();
        check("blink_state", state_o, 2'd2);
        for (int f = 0; f < 6; f++) begin
            apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
            check($sformatf("blink_f%0d", f), got, blink_exp[f]);
            frame_pulse();
        end
        game_en = 1'b0;
        win = 2'b00;
        frame_pulse();
        check("blink_exit", state_o, 2'd0);

        // Reset mid-line from WIN with winner 1.
        game_en = 1'b1;
        frame_pulse();
        win = 2'b10;
        frame_pulse();
        apply_px(11'd40, 11'd24, 1'b0, 1'b0, 12'h0C3, got);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_rgb", vout.rgb, 12'h000);
        check("mrst_hcount", vout.hcount, 11'd0);
        check("mrst_addr", pixel_addr, 14'd0);
        check("mrst_state", state_o, 2'd0);
        check("mrst_winner", winner_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        win = 2'b00;
        repeat (3) @(negedge clk);
        check("mrst_hold_menu", state_o, 2'd0);
        frame_pulse();
        check("mrst_game", state_o, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
